quant_index_packer: RTL and testbench
=====================================

Name: quant_index_packer

Overview:
- Downstream collector for the quantization divider chain (STAGES cascaded one-bit restoring-divider stages, each registered, each emitting an 8-bit index).
- Tracks which chain slots carry real activations and packs the final 8-bit indices four-per-word into 32-bit words.
- Buffers words in a small FIFO with a valid/ready output.
- The divider chain cannot stall, so the block issues a credit that gates upstream injection.

Parameters:
- STAGES, 8, number of divider stages between injection and i_index (pipeline latency in cycles).
- FIFO_DEPTH, 4, packed-word FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_issue  input  1  upstream injected an activation into stage 0 this cycle
- i_last  input  1  qualifies i_issue: final activation of tensor
- i_index  input  8  index from last divider stage
- i_ready  input  1  downstream accepts o_data this cycle
- o_credit  output  1  upstream may assert i_issue this cycle
- o_data  output  32  packed indices, lane0 = bits[7:0]
- o_keep  output  4  valid lanes of o_data
- o_last  output  1  word closes tensor
- o_valid  output  1  o_data/o_keep/o_last valid
- o_overflow  output  1  sticky: index arrived with FIFO full

Behaviour:
- Reset (async, reset_n low): tag delay line, lane register, lane_count, FIFO pointers/count, o_overflow all cleared. Outputs o_data=0, o_keep=0, o_last=0, o_valid=0, o_overflow=0, o_credit=1. Reset mid-operation discards all in-flight tags and buffered words. No partial flush.
- Tag line:
  - STAGES-deep shift register of {valid,last}. Stage 0 loads {i_issue, i_issue&i_last}.
  - Tag from cycle-t injection is at the tail at the edge t+STAGES, aligned with i_index for that activation.
  - inflight = popcount of valid bits in the line.
- Packing on a tail tag with valid=1:
  - Write i_index into lane[lane_count]; set keep bit.
  - If lane_count==3 or tag.last: push {lanes, keep, last} to FIFO. Clear lanes, keep, lane_count.
  - Otherwise lane_count+1.
  - Unused lanes of a partial word are 0.
  - i_index is ignored when the tail valid=0.
- FIFO:
  - Show-ahead. o_valid = count≠0. Outputs driven from head entry.
  - Pop when o_valid & i_ready.
  - Push and pop in the same cycle are both allowed, including when full; count unchanged.
  - Push when full without a pop: word dropped, o_overflow set until reset, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_data/o_keep/o_last hold while o_valid & !i_ready.
- Credit (combinational from registered state only):
  - o_credit = fifo_count + (lane_count≠0) + inflight < FIFO_DEPTH.
  - Conservative: every in-flight activation may close its own word.
  - Guarantees no overflow under a compliant upstream.
  - o_credit is independent of i_ready in the same cycle.
  - Credit freed by a pop is visible the following cycle.
- Latency: last index of a word reaches o_valid one cycle after it appears on i_index, so o_valid rises STAGES+1 cycles after the closing i_issue.
- i_issue while o_credit=0 is a protocol violation; the block behaves as specified (may overflow, flags it).

Test Plan:
- Reset then 4 issues (cycles 0–3), i_last on the 4th, i_index=0x11,0x22,0x33,0x44 at cycles 8–11, i_ready=1 → o_valid high in cycle 12 only: o_data=0x44332211, o_keep=0xF, o_last=1.
- 6 back-to-back issues (FIFO_DEPTH=16 build), last on 6th, indices 0x01..0x06 → word0 0x04030201 keep 0xF last 0; word1 0x00000605 keep 0x3 last 1.
- i_ready=0, issue only while o_credit=1, each with i_last → o_credit drops after 4 issues; exactly 4 words are queued, each keep=0x1 last=1; o_overflow stays 0. Raise i_ready → words drain in order; o_credit returns 1 the cycle after the first pop.
- FIFO full with i_ready=1 and a tail tag arriving in the same cycle → simultaneous push/pop; count stays FIFO_DEPTH, no overflow, order preserved across pointer wrap.
- Force i_issue with o_credit=0 into a full FIFO, i_ready=0 → o_overflow=1 stays sticky; FIFO contents unchanged.
- Assert reset_n low with 3 tags in flight and 2 lanes filled → all outputs 0 immediately; after release, no stale word appears on o_valid.

Source files
------------

// File: rtl/quant_index_packer_if.sv
// Bundle for the quantization index packer: upstream issue/credit and
// downstream word stream.
interface quant_index_packer_if;
    logic        i_issue;
    logic        i_last;
    logic [7:0]  i_index;
    logic        i_ready;
    logic        o_credit;
    logic [31:0] o_data;
    logic [3:0]  o_keep;
    logic        o_last;
    logic        o_valid;
    logic        o_overflow;

    // Packer side
    modport slave (
        input  i_issue, i_last, i_index, i_ready,
        output o_credit, o_data, o_keep, o_last, o_valid, o_overflow
    );

    // Driver / consumer side
    modport master (
        output i_issue, i_last, i_index, i_ready,
        input  o_credit, o_data, o_keep, o_last, o_valid, o_overflow
    );
endinterface

// File: rtl/quant_index_packer.sv
// Collects 8-bit indices from the end of the divider chain, packs them
// four per 32-bit word and queues the words in a show-ahead FIFO. A tag
// line shadows the divider chain so the packer knows which cycles carry
// real activations, and a conservative credit keeps upstream from ever
// overrunning the FIFO.
module quant_index_packer #(
    parameter int STAGES     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    quant_index_packer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = 16;

    logic [STAGES-1:0] tag_valid;
    logic [STAGES-1:0] tag_last;
    logic              tail_valid;
    logic              tail_last;
    logic [SW-1:0]     inflight;

    logic [31:0] lane_data, lane_data_nxt, word_data;
    logic [3:0]  lane_keep, lane_keep_nxt, word_keep;
    logic [1:0]  lane_count, lane_count_nxt;
    logic        push;

    logic [31:0] mem_data [FIFO_DEPTH];
    logic [3:0]  mem_keep [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_count;
    logic        fifo_full, pop, wr_en, ovf_q;
    logic [SW-1:0] credit_sum;

    assign tail_valid = tag_valid[STAGES-1];
    assign tail_last  = tag_last[STAGES-1];

    // Tag line: {valid,last} travels alongside the activation through the chain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= bus.i_issue;
            tag_last[0]  <= bus.i_issue & bus.i_last;
            for (int i = 1; i < STAGES; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    // Count activations still travelling through the divider chain
    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight = inflight + SW'(tag_valid[i]);
        end
    end

    // Lane packing: merge the arriving index, close the word on lane 3 or last
    always_comb begin
        lane_data_nxt  = lane_data;
        lane_keep_nxt  = lane_keep;
        lane_count_nxt = lane_count;
        push           = 1'b0;
        word_data      = lane_data;
        word_keep      = lane_keep | (4'b0001 << lane_count);
        word_data[{lane_count, 3'b000} +: 8] = bus.i_index;
        if (tail_valid) begin
            if (lane_count == 2'd3 || tail_last) begin
                push           = 1'b1;
                lane_data_nxt  = '0;
                lane_keep_nxt  = '0;
                lane_count_nxt = '0;
            end else begin
                lane_data_nxt  = word_data;
                lane_keep_nxt  = word_keep;
                lane_count_nxt = lane_count + 2'd1;
            end
        end
    end

    // Lane register holds the partially filled word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_data  <= '0;
            lane_keep  <= '0;
            lane_count <= '0;
        end else begin
            lane_data  <= lane_data_nxt;
            lane_keep  <= lane_keep_nxt;
            lane_count <= lane_count_nxt;
        end
    end

    // A push into a full FIFO still lands when the head leaves in the same cycle
    assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
    assign pop       = (fifo_count != '0) & bus.i_ready;
    assign wr_en     = push & (!fifo_full | pop);

    // FIFO storage; contents need no reset since outputs are gated by o_valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= word_data;
            mem_keep[wr_ptr] <= word_keep;
            mem_last[wr_ptr] <= tail_last;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!wr_en && pop) fifo_count <= fifo_count - CW'(1);
            if (push && fifo_full && !pop) ovf_q <= 1'b1;
        end
    end

    // Worst case every in-flight activation closes its own word
    assign credit_sum = SW'(fifo_count) + SW'(lane_count != 2'd0) + inflight;

    assign bus.o_credit   = (credit_sum < SW'(FIFO_DEPTH));
    assign bus.o_valid    = (fifo_count != '0);
    assign bus.o_data     = bus.o_valid ? mem_data[rd_ptr] : '0;
    assign bus.o_keep     = bus.o_valid ? mem_keep[rd_ptr] : '0;
    assign bus.o_last     = bus.o_valid ? mem_last[rd_ptr] : 1'b0;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_quant_index_packer.sv
// Self-checking bench for quant_index_packer: a queue-based reference model
// (pending activations, partial byte list, expected word FIFO) is stepped
// alongside the DUT and compared every cycle.
module tb_quant_index_packer;
    localparam int STAGES = 8;

    typedef struct packed { int arrive; bit last; } act_t;
    typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } word_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    quant_index_packer_if bus4();
    quant_index_packer_if bus16();

    quant_index_packer #(.STAGES(STAGES), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus4)
    );
    quant_index_packer #(.STAGES(STAGES), .FIFO_DEPTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16)
    );

    act_t       pend[$];
    word_t      mq[$];
    word_t      seen[$];
    logic [7:0] cur[$];
    logic [7:0] dir_idx[$];
    bit         m_ovf;
    bit         sel16;
    int         m_depth;
    int         cyc;
    int         total = 0;
    int         bad = 0;

    function automatic bit exp_credit();
        return (mq.size() + int'(cur.size() != 0) + pend.size()) < m_depth;
    endfunction

    task automatic set_inputs(input bit issue, input bit last, input logic [7:0] idx, input bit ready);
        bus4.i_issue  = issue;  bus16.i_issue = issue;
        bus4.i_last   = last;   bus16.i_last  = last;
        bus4.i_index  = idx;    bus16.i_index = idx;
        bus4.i_ready  = ready;  bus16.i_ready = ready;
    endtask

    // One clock cycle: compare DUT against model, drive inputs, advance model.
    task automatic step(input bit issue, input bit last, input bit ready);
        logic ov, oc, oo, ol;
        logic [31:0] od;
        logic [3:0] ok;
        logic [7:0] idx;
        bit arr, arr_last, pop;
        int sz;
        word_t w;
        if (sel16) begin
            ov = bus16.o_valid; oc = bus16.o_credit; oo = bus16.o_overflow;
            ol = bus16.o_last;  od = bus16.o_data;   ok = bus16.o_keep;
        end else begin
            ov = bus4.o_valid;  oc = bus4.o_credit;  oo = bus4.o_overflow;
            ol = bus4.o_last;   od = bus4.o_data;    ok = bus4.o_keep;
        end
        total++;
        if (ov !== (mq.size() != 0)) begin
            bad++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, ov, mq.size() != 0);
        end
        if (mq.size() != 0) begin
            total++;
            if (od !== mq[0].data) begin
                bad++; $display("FAIL data cyc=%0d got=%h exp=%h", cyc, od, mq[0].data);
            end
            total++;
            if (ok !== mq[0].keep) begin
                bad++; $display("FAIL keep cyc=%0d got=%h exp=%h", cyc, ok, mq[0].keep);
            end
            total++;
            if (ol !== mq[0].last) begin
                bad++; $display("FAIL last cyc=%0d got=%b exp=%b", cyc, ol, mq[0].last);
            end
        end
        total++;
        if (oc !== exp_credit()) begin
            bad++; $display("FAIL credit cyc=%0d got=%b exp=%b", cyc, oc, exp_credit());
        end
        total++;
        if (oo !== m_ovf) begin
            bad++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, oo, m_ovf);
        end

        arr = (pend.size() != 0) && (pend[0].arrive == cyc);
        idx = 8'($urandom);
        if (arr && dir_idx.size() != 0) idx = dir_idx.pop_front();
        set_inputs(issue, last, idx, ready);

        pop = (mq.size() != 0) && ready;
        sz  = mq.size();
        if (ov === 1'b1 && ready) seen.push_back('{od, ok, ol});
        if (pop) void'(mq.pop_front());
        if (arr) begin
            arr_last = pend[0].last;
            void'(pend.pop_front());
            cur.push_back(idx);
            if (cur.size() == 4 || arr_last) begin
                w = '{32'h0, 4'h0, arr_last};
                for (int i = 0; i < cur.size(); i++) begin
                    w.data[i*8 +: 8] = cur[i];
                    w.keep[i] = 1'b1;
                end
                cur.delete();
                if (sz == m_depth && !pop) m_ovf = 1'b1;
                else mq.push_back(w);
            end
        end
        if (issue) pend.push_back('{cyc + STAGES, last});
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit use16);
        reset_n = 1'b0;
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        sel16 = use16;
        m_depth = use16 ? 16 : 4;
        pend.delete(); mq.delete(); cur.delete(); seen.delete(); dir_idx.delete();
        m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus4.o_valid !== 1'b0 || bus4.o_data !== 32'h0 || bus4.o_keep !== 4'h0 ||
            bus4.o_last !== 1'b0 || bus4.o_overflow !== 1'b0 || bus4.o_credit !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h k=%h l=%b ov=%b cr=%b exp v=0 d=0 k=0 l=0 ov=0 cr=1",
                     bus4.o_valid, bus4.o_data, bus4.o_keep, bus4.o_last, bus4.o_overflow, bus4.o_credit);
        end
        total++;
        if (bus16.o_valid !== 1'b0 || bus16.o_credit !== 1'b1) begin
            bad++; $display("FAIL reset16 got v=%b cr=%b exp v=0 cr=1", bus16.o_valid, bus16.o_credit);
        end
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        dir_idx = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int c = 0; c < 4; c++) step(1'b1, c == 3, 1'b1);
        for (int c = 4; c < 12; c++) step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus4.o_valid !== 1'b1 || bus4.o_data !== 32'h44332211 || bus4.o_keep !== 4'hF || bus4.o_last !== 1'b1) begin
            bad++;
            $display("FAIL basic_word got v=%b d=%h k=%h l=%b exp v=1 d=44332211 k=f l=1",
                     bus4.o_valid, bus4.o_data, bus4.o_keep, bus4.o_last);
        end
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus4.o_valid !== 1'b0) begin
            bad++; $display("FAIL basic_one_cycle got v=%b exp v=0", bus4.o_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        dir_idx = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int c = 0; c < 6; c++) step(1'b1, c == 5, 1'b1);
        repeat (STAGES + 4) step(1'b0, 1'b0, 1'b1);
        total++;
        if (seen.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", seen.size());
        end else begin
            total++;
            if (seen[0] !== '{32'h04030201, 4'hF, 1'b0} || seen[1] !== '{32'h00000605, 4'h3, 1'b1}) begin
                bad++;
                $display("FAIL b2b_words got %h/%h/%b %h/%h/%b exp 04030201/f/0 00000605/3/1",
                         seen[0].data, seen[0].keep, seen[0].last, seen[1].data, seen[1].keep, seen[1].last);
            end
        end
        sel16 = 1'b0;
    endtask

    task automatic test_credit();
        int n = 0;
        bit ci;
        do_reset(1'b0);
        for (int c = 0; c < 12; c++) begin
            ci = exp_credit();
            step(ci, 1'b1, 1'b0);
            n += int'(ci);
        end
        total++;
        if (n != 4) begin
            bad++; $display("FAIL credit_issues got=%0d exp=4", n);
        end
        repeat (STAGES) step(1'b0, 1'b0, 1'b0);
        total++;
        if (bus4.o_credit !== 1'b0 || bus4.o_valid !== 1'b1) begin
            bad++; $display("FAIL credit_full got cr=%b v=%b exp cr=0 v=1", bus4.o_credit, bus4.o_valid);
        end
        repeat (8) step(1'b0, 1'b0, 1'b1);
        total++;
        if (seen.size() != 4) begin
            bad++; $display("FAIL credit_drain got=%0d exp=4", seen.size());
        end
    endtask

    task automatic test_full_pushpop();
        do_reset(1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 24; k++) step(k < 5, 1'b1, k >= 12);
        end
        total++;
        if (bus4.o_overflow !== 1'b0 || seen.size() != 15) begin
            bad++; $display("FAIL pushpop got ov=%b words=%0d exp ov=0 words=15", bus4.o_overflow, seen.size());
        end
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        for (int k = 0; k < 16; k++) step(k < 5, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus4.o_overflow !== 1'b1 || seen.size() != 4) begin
            bad++; $display("FAIL overflow_sticky got ov=%b words=%0d exp ov=1 words=4", bus4.o_overflow, seen.size());
        end
    endtask

    task automatic test_random();
        bit iss;
        do_reset(1'b0);
        for (int k = 0; k < 400; k++) begin
            iss = exp_credit() && ($urandom_range(0, 3) != 0);
            step(iss, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end
        step(1'b1, 1'b1, 1'b1);
        repeat (STAGES + 8) step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus4.o_overflow !== 1'b0 || bus4.o_valid !== 1'b0) begin
            bad++; $display("FAIL random_end got ov=%b v=%b exp ov=0 v=0", bus4.o_overflow, bus4.o_valid);
        end
    endtask

    task automatic test_reset_midop();
        do_reset(1'b0);
        for (int c = 0; c < 11; c++)
            step(c == 0 || c == 1 || c == 2 || c == 8 || c == 9 || c == 10, c == 0, 1'b0);
        total++;
        if (bus4.o_valid !== 1'b1) begin
            bad++; $display("FAIL midop_pre got v=%b exp v=1", bus4.o_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (bus4.o_valid !== 1'b0 || bus4.o_data !== 32'h0 || bus4.o_keep !== 4'h0 ||
            bus4.o_last !== 1'b0 || bus4.o_overflow !== 1'b0 || bus4.o_credit !== 1'b1) begin
            bad++;
            $display("FAIL midop_async got v=%b d=%h k=%h l=%b ov=%b cr=%b exp v=0 d=0 k=0 l=0 ov=0 cr=1",
                     bus4.o_valid, bus4.o_data, bus4.o_keep, bus4.o_last, bus4.o_overflow, bus4.o_credit);
        end
        do_reset(1'b0);
        repeat (STAGES + 12) step(1'b0, 1'b0, 1'b1);
        total++;
        if (seen.size() != 0) begin
            bad++; $display("FAIL midop_stale got words=%0d exp words=0", seen.size());
        end
    endtask

    initial begin
        set_inputs(1'b0, 1'b0, 8'h00, 1'b0);
        sel16 = 1'b0;
        m_depth = 4;
        cyc = 0;
        m_ovf = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_credit();
        test_full_pushpop();
        test_overflow();
        test_random();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
